demux4_12: RTL

- 1-to-4 stream demultiplexer for 12-bit words; the distribution counterpart of the 4:1 12-bit word selector.
- Accepts one word per cycle on a valid/ready input and routes it to one of four output lanes chosen by a 2-bit select.
- Each lane has a one-entry holding register, so a stalled lane never blocks the other lanes.
- Each lane also keeps a saturating count of delivered words.

---
 rtl/demux4_12_pkg.sv | 14 +
 rtl/demux4_12_lane_slot.sv | 43 ++++
 rtl/demux4_12.sv | 58 +++++
 3 files changed

// File: rtl/demux4_12_pkg.sv
// Shared types and helpers for the 1-to-4 word demultiplexer.
package demux_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_t;

  // Saturating increment: holds at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/demux4_12_lane_slot.sv
// One output lane: single-entry holding register plus saturating delivered-word counter.
module lane_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic drain;

  assign drain = out_valid && out_ready;

  // A load overrides a simultaneous drain so the lane sustains one word per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain) begin
        cnt <= CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
      end
    end
  end

endmodule

// File: rtl/demux4_12.sv
// 1-to-4 stream demultiplexer for 12-bit words with per-lane holding registers and counters.
module demux4_12
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  lane_t                  in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*CNT_W-1:0] out_cnt
);

  logic [LANES-1:0] full;
  logic [LANES-1:0] load;

  // Only the selected lane gates acceptance; other lanes may be stalled freely.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = !full[in_sel] || out_ready[in_sel];
    end
  end

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (in_valid && in_ready && (in_sel == lane_t'(k))) begin
        load[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_valid (full[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .cnt       (out_cnt[k*CNT_W +: CNT_W])
    );
  end

  assign out_valid = full;

endmodule
